beam_delay_scheduler: RTL and testbench
=======================================

Name: beam_delay_scheduler

Overview:
Controller that owns the per-channel delay read indices feeding the channel buffers of the beamformer.
- Host writes new delays into shadow registers through a valid/ready port.
- A commit request arms the block; the shadow set is transferred to the active indices only at the next frame boundary (ws falling edge), so all channels change in the same frame.
- Sits between the host-facing config pins and the channel buffer read_index inputs.

Parameters:
NUM_CH, 8, number of delay taps (2 per I2S input: left and right).
IDX_W, 4, width of one delay index (log2 of buffer depth, 16).
SEL_W, 4, width of the channel select field.
CNT_W, 8, width of the frames-since-commit counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ws  in  1  word-select/frame clock; generated in the clk domain, so no synchronizer
cfg_valid  in  1  host write request
cfg_ready  out  1  shadow registers accept a write
cfg_sel  in  SEL_W  target channel
cfg_index  in  IDX_W  new delay for target channel
commit_req  in  1  request a commit at the next frame boundary
commit_done  out  1  one-cycle pulse after the active set is updated
armed  out  1  commit pending, waiting for the frame boundary
sel_err  out  1  sticky flag: write to cfg_sel >= NUM_CH
delay_active  out  NUM_CH*IDX_W  active indices, channel k at bits [k*IDX_W +: IDX_W]
frame_count  out  CNT_W  frames since last commit, saturating

Behaviour:
- Reset: shadow and active all 0; cfg_ready=1; armed=0; commit_done=0; sel_err=0; frame_count=0; ws_d=0; FSM in IDLE. A reset mid-ARMED drops the pending commit.
- Frame boundary: fb = ws_d & ~ws, where ws_d is ws registered each clk.
- FSM IDLE:
  - cfg_ready=1.
  - On cfg_valid and cfg_sel < NUM_CH, shadow[cfg_sel] <= cfg_index.
  - On cfg_valid and cfg_sel >= NUM_CH, the write is dropped and sel_err <= 1.
  - On commit_req, go to ARMED. A write in the same cycle is applied first and is part of the commit.
- FSM ARMED:
  - armed=1 and cfg_ready=0; writes are ignored and do not set sel_err.
  - commit_req is ignored.
  - On fb, go to APPLY.
- FSM APPLY (one cycle):
  - active <= shadow (all channels in the same edge); frame_count <= 0; sel_err <= 0.
  - Return to IDLE.
  - commit_done is high in the cycle after APPLY, when the new delay_active is already visible.
- Latency: fb seen in cycle t, active updated at the end of t+1, commit_done high in t+2. If commit_req is asserted in the same cycle as fb, the commit waits for the next boundary.
- frame_count:
  - Increments on each fb when not in APPLY.
  - Saturates at 2^CNT_W-1.
- delay_active is registered with no combinational path from the inputs.
- Indices wrap naturally modulo 2^IDX_W; no range check beyond IDX_W.

Optional Feature:
Macro DELAY_RAMP_EN.
- Defined:
  - APPLY no longer copies shadow to active. It loads target <= shadow and enters RAMP.
  - In RAMP, on each fb, every active[k] != target[k] moves one step toward target[k] (+1 or -1, no wrap).
  - When all channels match, commit_done pulses on the next cycle and the FSM returns to IDLE.
  - armed stays 1 and cfg_ready stays 0 throughout RAMP.
  - frame_count is cleared at APPLY and increments in RAMP as normal.
- Undefined: single-step update as described above; no target registers exist.

Test Plan:
- Reset, then hold ws toggling every 16 clk -> delay_active=0, cfg_ready=1, frame_count saturates at 255 after 255 frames.
- Write ch3=5 and ch6=12, pulse commit_req -> armed=1 until the next ws fall; active ch3=5 and ch6=12 at fb+1; commit_done at fb+2; all other channels stay 0.
- Write cfg_sel=9 with cfg_index=7 -> no channel changes, sel_err=1; sel_err clears after the next commit completes.
- In ARMED, write ch0=15 -> ignored (cfg_ready=0); the commit applies the pre-arm shadow and ch0 stays at its old value.
- Assert reset while ARMED, then let ws fall -> no commit_done, active stays 0, armed=0.
- With DELAY_RAMP_EN: ch1 goes 0->3 -> active ch1 reads 1, 2, 3 on three successive frame boundaries; commit_done pulses once, after 3 is reached.

Source files
------------

// File: rtl/beam_delay_scheduler.sv
// Per-channel delay index controller: host writes go to shadow registers and are committed to the active set at a ws falling edge.
// Optional macro DELAY_RAMP_EN: the active indices step one count per frame toward the committed targets instead of jumping.
module beam_delay_scheduler #(
    parameter int NUM_CH = 8,
    parameter int IDX_W  = 4,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ws,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [SEL_W-1:0]          cfg_sel,
    input  logic [IDX_W-1:0]          cfg_index,
    input  logic                      commit_req,
    output logic                      commit_done,
    output logic                      armed,
    output logic                      sel_err,
    output logic [NUM_CH*IDX_W-1:0]   delay_active,
    output logic [CNT_W-1:0]          frame_count
);
    localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [SEL_W:0]  NUM_CH_S = (SEL_W+1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd2,
        ST_RAMP  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   shadow_r [NUM_CH];
    logic [IDX_W-1:0]   active_r [NUM_CH];
    logic               ws_d_r;
    logic               fb_s;
    logic               sel_ok_s;
    logic [CH_W-1:0]    sel_idx_s;
    logic               wr_en_s;
    logic               err_set_s;
    logic               apply_s;
    logic               done_s;
    logic               cfg_ready_r;
    logic               armed_r;
    logic               commit_done_r;
    logic               sel_err_r;
    logic [CNT_W-1:0]   frame_count_r;
`ifdef DELAY_RAMP_EN
    logic [IDX_W-1:0]   target_r [NUM_CH];
    logic               all_match_s;
    logic               step_s;
`endif

    assign fb_s      = ws_d_r & ~ws;
    assign sel_ok_s  = ({1'b0, cfg_sel} < NUM_CH_S);
    assign sel_idx_s = cfg_sel[CH_W-1:0];

`ifdef DELAY_RAMP_EN
    // Ramp completes once every active index has reached its target.
    always_comb begin
        all_match_s = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (active_r[k] != target_r[k]) begin
                all_match_s = 1'b0;
            end else begin
                all_match_s = all_match_s;
            end
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_s   = state_r;
        wr_en_s   = 1'b0;
        err_set_s = 1'b0;
        apply_s   = 1'b0;
        done_s    = 1'b0;
`ifdef DELAY_RAMP_EN
        step_s    = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (cfg_valid) begin
                    wr_en_s   = sel_ok_s;
                    err_set_s = ~sel_ok_s;
                end else begin
                    wr_en_s   = 1'b0;
                    err_set_s = 1'b0;
                end
                // A same-cycle write lands in the shadow before the commit is taken.
                if (commit_req) begin
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (fb_s) begin
                    state_s = ST_APPLY;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_APPLY: begin
                apply_s = 1'b1;
`ifdef DELAY_RAMP_EN
                state_s = ST_RAMP;
`else
                state_s = ST_IDLE;
                done_s  = 1'b1;
`endif
            end
            ST_RAMP: begin
`ifdef DELAY_RAMP_EN
                if (all_match_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_RAMP;
                    step_s  = fb_s;
                end
`else
                state_s = ST_IDLE;
`endif
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs registered from the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_ready_r   <= 1'b1;
            armed_r       <= 1'b0;
            commit_done_r <= 1'b0;
            ws_d_r        <= 1'b0;
        end else begin
            cfg_ready_r   <= (state_s == ST_IDLE);
            armed_r       <= (state_s != ST_IDLE);
            commit_done_r <= done_s;
            ws_d_r        <= ws;
        end
    end

    // Sticky select error and saturating frames-since-commit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_r     <= 1'b0;
            frame_count_r <= '0;
        end else begin
            if (apply_s) begin
                sel_err_r <= 1'b0;
            end else if (err_set_s) begin
                sel_err_r <= 1'b1;
            end else begin
                sel_err_r <= sel_err_r;
            end
            if (apply_s) begin
                frame_count_r <= '0;
            end else if (fb_s && (frame_count_r != CNT_MAX)) begin
                frame_count_r <= frame_count_r + CNT_W'(1);
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    // Shadow write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_r[k] <= '0;
            end
        end else if (wr_en_s) begin
            shadow_r[sel_idx_s] <= cfg_index;
        end else begin
            shadow_r <= shadow_r;
        end
    end

`ifdef DELAY_RAMP_EN
    // Targets latch the shadow at APPLY; active walks toward them one step per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                target_r[k] <= '0;
                active_r[k] <= '0;
            end
        end else begin
            if (apply_s) begin
                target_r <= shadow_r;
            end else begin
                target_r <= target_r;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (step_s && (active_r[k] < target_r[k])) begin
                    active_r[k] <= active_r[k] + IDX_W'(1);
                end else if (step_s && (active_r[k] > target_r[k])) begin
                    active_r[k] <= active_r[k] - IDX_W'(1);
                end else begin
                    active_r[k] <= active_r[k];
                end
            end
        end
    end
`else
    // All channels take the shadow set on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                active_r[k] <= '0;
            end
        end else if (apply_s) begin
            active_r <= shadow_r;
        end else begin
            active_r <= active_r;
        end
    end
`endif

    // Flatten the active set onto the output bus.
    always_comb begin
        delay_active = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            delay_active[k*IDX_W +: IDX_W] = active_r[k];
        end
    end

    assign cfg_ready   = cfg_ready_r;
    assign armed       = armed_r;
    assign commit_done = commit_done_r;
    assign sel_err     = sel_err_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_beam_delay_scheduler.sv
// Bench for beam_delay_scheduler: event-level reference model checked every cycle, plus directed literal checks.
module tb_beam_delay_scheduler;
    localparam int NUM_CH = 8;
    localparam int IDX_W  = 4;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ws = 1'b0;
    logic cfg_valid = 1'b0;
    logic cfg_ready;
    logic [SEL_W-1:0] cfg_sel = '0;
    logic [IDX_W-1:0] cfg_index = '0;
    logic commit_req = 1'b0;
    logic commit_done;
    logic armed;
    logic sel_err;
    logic [NUM_CH*IDX_W-1:0] delay_active;
    logic [CNT_W-1:0] frame_count;

    int n_checks = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    int ws_half = 16;
    int ws_cnt = 0;

    beam_delay_scheduler #(.NUM_CH(NUM_CH), .IDX_W(IDX_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ws(ws), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel), .cfg_index(cfg_index), .commit_req(commit_req),
        .commit_done(commit_done), .armed(armed), .sel_err(sel_err),
        .delay_active(delay_active), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Frame clock in the clk domain: toggles every ws_half cycles.
    always @(negedge clk) begin
        ws_cnt = ws_cnt + 1;
        if (ws_cnt >= ws_half) begin
            ws_cnt = 0;
            ws = ~ws;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model (event level) ----------------
    logic [IDX_W-1:0] m_shadow [NUM_CH];
    logic [IDX_W-1:0] m_active [NUM_CH];
    logic [IDX_W-1:0] m_target [NUM_CH];
    bit m_busy, m_wait, m_ramp, m_sel_err, m_done, m_ws_prev;
    int m_frames;
    longint cyc = 0;
    longint m_apply_at = -1;

    function automatic logic [NUM_CH*IDX_W-1:0] m_pack();
        logic [NUM_CH*IDX_W-1:0] r;
        for (int k = 0; k < NUM_CH; k++) r[k*IDX_W +: IDX_W] = m_active[k];
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit fb;
        bit done_nx;
        int diff;
        fb = m_ws_prev && !ws;
        done_nx = 1'b0;
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_shadow[k] = '0; m_active[k] = '0; m_target[k] = '0;
            end
            m_busy = 0; m_wait = 0; m_ramp = 0; m_sel_err = 0; m_frames = 0; m_apply_at = -1;
        end else begin
            if (cyc == m_apply_at) m_frames = 0;
            else if (fb) m_frames++;
            if (!m_busy) begin
                if (cfg_valid) begin
                    if (int'(cfg_sel) < NUM_CH) m_shadow[cfg_sel[2:0]] = cfg_index;
                    else m_sel_err = 1;
                end
                if (commit_req) begin m_busy = 1; m_wait = 1; end
            end else if (m_wait) begin
                if (fb) begin m_wait = 0; m_apply_at = cyc + 1; end
            end else if (cyc == m_apply_at) begin
                m_apply_at = -1;
                m_sel_err = 0;
`ifdef DELAY_RAMP_EN
                for (int k = 0; k < NUM_CH; k++) m_target[k] = m_shadow[k];
                m_ramp = 1;
`else
                for (int k = 0; k < NUM_CH; k++) m_active[k] = m_shadow[k];
                m_busy = 0;
                done_nx = 1;
`endif
            end else if (m_ramp) begin
                diff = 0;
                for (int k = 0; k < NUM_CH; k++) if (m_active[k] != m_target[k]) diff++;
                if (diff == 0) begin
                    m_ramp = 0; m_busy = 0; done_nx = 1;
                end else if (fb) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (m_active[k] < m_target[k]) m_active[k] = m_active[k] + 1'b1;
                        else if (m_active[k] > m_target[k]) m_active[k] = m_active[k] - 1'b1;
                    end
                end
            end
        end
        m_done = done_nx;
        m_ws_prev = ws;
        cyc++;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cfg_ready", cfg_ready, !m_busy);
            check("armed", armed, m_busy);
            check("commit_done", commit_done, m_done);
            check("sel_err", sel_err, m_sel_err);
            check("delay_active", delay_active, m_pack());
            check("frame_count", frame_count, (m_frames > 255) ? 255 : m_frames);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_write(input int sel, input int idx);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_sel = SEL_W'(sel); cfg_index = IDX_W'(idx);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic do_commit();
        @(negedge clk);
        commit_req = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
    endtask

    task automatic sync_fb();
        int i = 0;
        while (ws !== 1'b1 && i < 200) begin @(negedge clk); i++; end
        while (ws !== 1'b0 && i < 200) begin @(negedge clk); i++; end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (commit_done === 1'b1) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (seen) n_pass++;
        else $display("FAIL %s: commit_done not seen within %0d cycles", name, budget);
    endtask

    int done_cnt;
    int ramp_q[$];
    logic [IDX_W-1:0] prev_ch1;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_active", delay_active, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_armed", armed, 0);
        check("rst_count", frame_count, 0);
        reset = 1'b0;

        // Saturation after 255 frames of 32 clk each.
        repeat (260 * 32) @(negedge clk);
        check("count_sat", frame_count, 255);

        // ch3=5, ch6=12 commit.
        sync_fb();
        do_write(3, 5);
        do_write(6, 12);
        do_commit();
        check("armed_wait", armed, 1);
        wait_done("commit1", 600);
        check("commit1_active", delay_active, 32'h0C00_5000);
        check("commit1_armed", armed, 0);
`ifndef DELAY_RAMP_EN
        check("commit1_count", frame_count, 0);
`endif

        // Out-of-range select.
        do_write(9, 7);
        check("sel_err_set", sel_err, 1);
        check("sel_err_noop", delay_active, 32'h0C00_5000);
        sync_fb();
        do_commit();
        wait_done("commit2", 600);
        check("sel_err_clr", sel_err, 0);

        // Write during ARMED is ignored.
        sync_fb();
        do_write(2, 9);
        do_commit();
        check("armed_ready", cfg_ready, 0);
        do_write(0, 15);
        wait_done("commit3", 600);
        check("armed_write_ignored", delay_active, 32'h0C00_5900);

        // Reset while ARMED drops the commit.
        sync_fb();
        do_write(1, 4);
        do_commit();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("rst_armed_drop", armed, 0);
        done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (commit_done === 1'b1) done_cnt++;
        end
        check("rst_no_done", done_cnt, 0);
        check("rst_active_zero", delay_active, 0);

`ifdef DELAY_RAMP_EN
        sync_fb();
        do_write(1, 3);
        do_commit();
        prev_ch1 = '0;
        done_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (delay_active[7:4] != prev_ch1) begin
                prev_ch1 = delay_active[7:4];
                ramp_q.push_back(int'(prev_ch1));
            end
            if (commit_done === 1'b1) done_cnt++;
        end
        check("ramp_steps", ramp_q.size(), 3);
        if (ramp_q.size() == 3) begin
            check("ramp_1", ramp_q[0], 1);
            check("ramp_2", ramp_q[1], 2);
            check("ramp_3", ramp_q[2], 3);
        end
        check("ramp_done_once", done_cnt, 1);
`endif

        // Randomized traffic with varying frame length and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 200 == 0) ws_half = $urandom_range(2, 9);
            cfg_valid  = 1'($urandom_range(0, 1));
            cfg_sel    = SEL_W'($urandom_range(0, 11));
            cfg_index  = IDX_W'($urandom);
            commit_req = ($urandom_range(0, 9) == 0);
            reset      = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        cfg_valid = 1'b0; commit_req = 1'b0; reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
